// File: rtl/pong_controller_if.sv
// Status flags from the pong datapath and the sel_*/en_* controls back to it.
interface pong_controller_if;
  logic       start;
  logic       x_sign, y_sign;
  logic       paddle_up, paddle_down, ai_up, ai_down;
  logic       ball_too_high, ball_too_low;
  logic       paddle_too_high, paddle_too_low;
  logic       ai_too_high, ai_too_low;
  logic       player_collision, ai_collision;
  logic       player_scored, ai_scored, game_over;
  logic [1:0] sel_x_ball, sel_y_ball, sel_y_paddle, sel_y_ai;
  logic       en_x_ball, en_y_ball, en_y_paddle, en_y_ai;
  logic       sel_player_score, en_player_score, sel_ai_score, en_ai_score;

  modport master (
    input  start, x_sign, y_sign, paddle_up, paddle_down, ai_up, ai_down,
           ball_too_high, ball_too_low, paddle_too_high, paddle_too_low,
           ai_too_high, ai_too_low, player_collision, ai_collision,
           player_scored, ai_scored, game_over,
    output sel_x_ball, sel_y_ball, sel_y_paddle, sel_y_ai,
           en_x_ball, en_y_ball, en_y_paddle, en_y_ai,
           sel_player_score, en_player_score, sel_ai_score, en_ai_score
  );

  modport slave (
    output start, x_sign, y_sign, paddle_up, paddle_down, ai_up, ai_down,
           ball_too_high, ball_too_low, paddle_too_high, paddle_too_low,
           ai_too_high, ai_too_low, player_collision, ai_collision,
           player_scored, ai_scored, game_over,
    input  sel_x_ball, sel_y_ball, sel_y_paddle, sel_y_ai,
           en_x_ball, en_y_ball, en_y_paddle, en_y_ai,
           sel_player_score, en_player_score, sel_ai_score, en_ai_score
  );
endinterface

// File: rtl/pong_controller.sv
// Pong game-sequencing FSM: paces play with a frame-tick divider and drives the
// datapath mux selects and load enables from state and status flags.
module pong_controller #(
  parameter int CNT_W       = 20,
  parameter int TICK_DIV    = 833333,
  parameter int HOLD_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  pong_controller_if.master dp,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    INIT  = 4'd0,
    IDLE  = 4'd1,
    WAIT  = 4'd2,
    MOVE  = 4'd3,
    CHECK = 4'd4,
    SCORE = 4'd5,
    SERVE = 4'd6,
    HOLD  = 4'd7,
    OVER  = 4'd8
  } state_t;

  localparam logic [1:0] SEL_HOME = 2'd0;
  localparam logic [1:0] SEL_INC  = 2'd1;
  localparam logic [1:0] SEL_DEC  = 2'd2;
  localparam logic [1:0] SEL_HOLD = 2'd3;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             scorer, scorer_nxt;

  // Paddle motion: up wins over down; a blocked or idle paddle holds position.
  function automatic logic [1:0] key_sel(input logic up, input logic down,
                                         input logic too_high, input logic too_low);
    if (up && !too_high)      return SEL_INC;
    else if (down && !too_low) return SEL_DEC;
    else                       return SEL_HOLD;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= INIT;
      cnt    <= '0;
      scorer <= 1'b0;
    end else begin
      cur    <= nxt;
      cnt    <= cnt_nxt;
      scorer <= scorer_nxt;
    end
  end

  always_comb begin
    nxt                 = cur;
    cnt_nxt             = '0;
    scorer_nxt          = scorer;
    dp.sel_x_ball       = SEL_HOME;
    dp.sel_y_ball       = SEL_HOME;
    dp.sel_y_paddle     = SEL_HOME;
    dp.sel_y_ai         = SEL_HOME;
    dp.en_x_ball        = 1'b0;
    dp.en_y_ball        = 1'b0;
    dp.en_y_paddle      = 1'b0;
    dp.en_y_ai          = 1'b0;
    dp.sel_player_score = 1'b0;
    dp.en_player_score  = 1'b0;
    dp.sel_ai_score     = 1'b0;
    dp.en_ai_score      = 1'b0;

    case (cur)
      INIT: begin
        dp.en_x_ball       = 1'b1;
        dp.en_y_ball       = 1'b1;
        dp.en_y_paddle     = 1'b1;
        dp.en_y_ai         = 1'b1;
        dp.en_player_score = 1'b1;
        dp.en_ai_score     = 1'b1;
        nxt                = IDLE;
      end
      IDLE: if (dp.start) nxt = WAIT;
      WAIT: begin
        if (cnt == TICK_LAST) nxt = MOVE;
        else cnt_nxt = cnt + CNT_W'(1);
      end
      MOVE: begin
        dp.en_x_ball   = 1'b1;
        dp.en_y_ball   = 1'b1;
        dp.en_y_paddle = 1'b1;
        dp.en_y_ai     = 1'b1;
        if (dp.player_collision && !dp.x_sign) dp.sel_x_ball = SEL_INC;
        else if (dp.ai_collision && dp.x_sign) dp.sel_x_ball = SEL_DEC;
        else dp.sel_x_ball = dp.x_sign ? SEL_INC : SEL_DEC;
        if (dp.ball_too_high)     dp.sel_y_ball = SEL_DEC;
        else if (dp.ball_too_low) dp.sel_y_ball = SEL_INC;
        else dp.sel_y_ball = dp.y_sign ? SEL_INC : SEL_DEC;
        dp.sel_y_paddle = key_sel(dp.paddle_up, dp.paddle_down,
                                  dp.paddle_too_high, dp.paddle_too_low);
        dp.sel_y_ai     = key_sel(dp.ai_up, dp.ai_down, dp.ai_too_high, dp.ai_too_low);
        nxt = CHECK;
      end
      CHECK: begin
        if (dp.player_scored) begin
          nxt        = SCORE;
          scorer_nxt = 1'b0;
        end else if (dp.ai_scored) begin
          nxt        = SCORE;
          scorer_nxt = 1'b1;
        end else begin
          nxt = WAIT;
        end
      end
      SCORE: begin
        if (!scorer) begin
          dp.sel_player_score = 1'b1;
          dp.en_player_score  = 1'b1;
        end else begin
          dp.sel_ai_score = 1'b1;
          dp.en_ai_score  = 1'b1;
        end
        nxt = SERVE;
      end
      SERVE: begin
        dp.en_x_ball   = 1'b1;
        dp.en_y_ball   = 1'b1;
        dp.en_y_paddle = 1'b1;
        dp.en_y_ai     = 1'b1;
        nxt = dp.game_over ? OVER : HOLD;
      end
      HOLD: begin
        if (cnt == HOLD_LAST) nxt = WAIT;
        else cnt_nxt = cnt + CNT_W'(1);
      end
      OVER: if (dp.start) nxt = INIT;
      default: nxt = INIT;
    endcase

    // A reset cycle must never leak a partial datapath update.
    if (rst) begin
      dp.sel_x_ball       = SEL_HOME;
      dp.sel_y_ball       = SEL_HOME;
      dp.sel_y_paddle     = SEL_HOME;
      dp.sel_y_ai         = SEL_HOME;
      dp.en_x_ball        = 1'b0;
      dp.en_y_ball        = 1'b0;
      dp.en_y_paddle      = 1'b0;
      dp.en_y_ai          = 1'b0;
      dp.sel_player_score = 1'b0;
      dp.en_player_score  = 1'b0;
      dp.sel_ai_score     = 1'b0;
      dp.en_ai_score      = 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pong_controller.sv
// Scoreboard bench for pong_controller with a short tick/hold, datapath flags driven directly.
module tb_pong_controller;

  localparam logic [3:0] S_INIT = 4'd0, S_IDLE = 4'd1, S_WAIT = 4'd2, S_MOVE = 4'd3,
                         S_CHECK = 4'd4, S_SCORE = 4'd5, S_SERVE = 4'd6, S_HOLD = 4'd7,
                         S_OVER = 4'd8;
  localparam logic [3:0] EN_NONE = 4'b0000, EN_ALL = 4'b1111;
  // {sel_player_score, en_player_score, sel_ai_score, en_ai_score}
  localparam logic [3:0] SC_NONE = 4'b0000, SC_CLEAR = 4'b0101,
                         SC_PLAYER = 4'b1100, SC_AI = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic [19:0] obs;
  logic [19:0] exp_q[$];
  logic [19:0] exp_v;
  int total = 0;
  int bad   = 0;
  bit found;

  pong_controller_if dp();

  pong_controller #(.CNT_W(20), .TICK_DIV(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .dp(dp), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, dp.sel_x_ball, dp.sel_y_ball, dp.sel_y_paddle, dp.sel_y_ai,
                dp.en_x_ball, dp.en_y_ball, dp.en_y_paddle, dp.en_y_ai,
                dp.sel_player_score, dp.en_player_score, dp.sel_ai_score, dp.en_ai_score};

  function automatic logic [19:0] pk(input logic [3:0] st, input logic [1:0] sx,
                                     input logic [1:0] sy, input logic [1:0] sp,
                                     input logic [1:0] sa, input logic [3:0] en,
                                     input logic [3:0] sc);
    return {st, sx, sy, sp, sa, en, sc};
  endfunction

  task automatic clear_flags();
    dp.start = 0; dp.x_sign = 0; dp.y_sign = 0;
    dp.paddle_up = 0; dp.paddle_down = 0; dp.ai_up = 0; dp.ai_down = 0;
    dp.ball_too_high = 0; dp.ball_too_low = 0;
    dp.paddle_too_high = 0; dp.paddle_too_low = 0;
    dp.ai_too_high = 0; dp.ai_too_low = 0;
    dp.player_collision = 0; dp.ai_collision = 0;
    dp.player_scored = 0; dp.ai_scored = 0; dp.game_over = 0;
  endtask

  task automatic wait_state(input logic [3:0] target, output bit hit);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state == target) begin
        hit = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_q.push_back(pk(S_INIT, 0, 0, 0, 0, EN_NONE, SC_NONE));
    #1 exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    @(negedge clk);
    rst = 0;
    exp_q.push_back(pk(S_INIT, 0, 0, 0, 0, EN_ALL, SC_CLEAR));
    #1 exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL init_cycle: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_q.push_back(pk(S_IDLE, 0, 0, 0, 0, EN_NONE, SC_NONE));
      #1 exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL idle: got %h want %h", obs, exp_v); end
    end
  endtask

  task automatic test_tick();
    @(negedge clk);
    dp.start = 1;
    exp_q.push_back(pk(S_IDLE, 0, 0, 0, 0, EN_NONE, SC_NONE));
    #1 exp_v = exp_q.pop_front(); total++;
    if (obs !== exp_v) begin bad++; $display("FAIL start_idle: got %h want %h", obs, exp_v); end
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < 4; w++) exp_q.push_back(pk(S_WAIT, 0, 0, 0, 0, EN_NONE, SC_NONE));
      exp_q.push_back(pk(S_MOVE, 2, 2, 3, 3, EN_ALL, SC_NONE));
      exp_q.push_back(pk(S_CHECK, 0, 0, 0, 0, EN_NONE, SC_NONE));
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        dp.start = 0;
        #1 exp_v = exp_q.pop_front(); total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL tick_period p%0d c%0d: got %h want %h", p, c, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_move_priority();
    // Round 1: collision bounce, both y bounds (high wins), blocked paddle, ai down.
    dp.x_sign = 0; dp.player_collision = 1; dp.ball_too_high = 1; dp.ball_too_low = 1;
    dp.paddle_up = 1; dp.paddle_too_high = 1; dp.ai_down = 1;
    exp_q.push_back(pk(S_MOVE, 1, 2, 3, 2, EN_ALL, SC_NONE));
    // Round 2: ai bounce, low bound, paddle down, ai up.
    exp_q.push_back(pk(S_MOVE, 2, 1, 2, 1, EN_ALL, SC_NONE));
    // Round 3: free flight positive, up beats down, ai down blocked.
    exp_q.push_back(pk(S_MOVE, 1, 1, 1, 3, EN_ALL, SC_NONE));
    for (int r = 0; r < 3; r++) begin
      wait_state(S_MOVE, found);
      total++;
      if (!found) begin bad++; $display("FAIL move_timeout r%0d: got %h want %h", r, state, S_MOVE); end
      #1 exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL move_sel r%0d: got %h want %h", r, obs, exp_v); end
      @(negedge clk);
      clear_flags();
      if (r == 0) begin
        dp.x_sign = 1; dp.ai_collision = 1; dp.ball_too_low = 1;
        dp.paddle_down = 1; dp.ai_up = 1;
      end else if (r == 1) begin
        dp.x_sign = 1; dp.y_sign = 1; dp.player_collision = 1;
        dp.paddle_up = 1; dp.paddle_down = 1; dp.ai_down = 1; dp.ai_too_low = 1;
      end
    end
    clear_flags();
  endtask

  task automatic test_score();
    wait_state(S_MOVE, found);
    total++;
    if (!found) begin bad++; $display("FAIL score_timeout: got %h want %h", state, S_MOVE); end
    @(negedge clk);
    dp.player_scored = 1; dp.ai_scored = 1;
    exp_q.push_back(pk(S_CHECK, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_SCORE, 0, 0, 0, 0, EN_NONE, SC_PLAYER));
    exp_q.push_back(pk(S_SERVE, 0, 0, 0, 0, EN_ALL, SC_NONE));
    for (int h = 0; h < 8; h++) exp_q.push_back(pk(S_HOLD, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_WAIT, 0, 0, 0, 0, EN_NONE, SC_NONE));
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dp.player_scored = 0; dp.ai_scored = 0;
      end
      #1 exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL score_seq c%0d: got %h want %h", c, obs, exp_v); end
    end
  endtask

  task automatic test_game_over();
    wait_state(S_MOVE, found);
    total++;
    if (!found) begin bad++; $display("FAIL over_timeout: got %h want %h", state, S_MOVE); end
    @(negedge clk);
    dp.ai_scored = 1;
    exp_q.push_back(pk(S_CHECK, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_SCORE, 0, 0, 0, 0, EN_NONE, SC_AI));
    exp_q.push_back(pk(S_SERVE, 0, 0, 0, 0, EN_ALL, SC_NONE));
    for (int h = 0; h < 21; h++) exp_q.push_back(pk(S_OVER, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_INIT, 0, 0, 0, 0, EN_ALL, SC_CLEAR));
    exp_q.push_back(pk(S_IDLE, 0, 0, 0, 0, EN_NONE, SC_NONE));
    for (int c = 0; c < 26; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dp.ai_scored = 0;
        dp.game_over = (c < 24);
        dp.paddle_up = (c > 3 && c < 10);
        dp.start = (c == 23);
      end
      #1 exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL over_seq c%0d: got %h want %h", c, obs, exp_v); end
    end
    clear_flags();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dp.start = 1;
    #1;
    @(negedge clk);
    dp.start = 0;
    wait_state(S_MOVE, found);
    total++;
    if (!found) begin bad++; $display("FAIL rstmid_timeout: got %h want %h", state, S_MOVE); end
    rst = 1;
    exp_q.push_back(pk(S_MOVE, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_INIT, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_INIT, 0, 0, 0, 0, EN_ALL, SC_CLEAR));
    exp_q.push_back(pk(S_IDLE, 0, 0, 0, 0, EN_NONE, SC_NONE));
    for (int w = 0; w < 4; w++) exp_q.push_back(pk(S_WAIT, 0, 0, 0, 0, EN_NONE, SC_NONE));
    exp_q.push_back(pk(S_MOVE, 2, 2, 3, 3, EN_ALL, SC_NONE));
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        @(negedge clk);
        rst = (c < 2);
        dp.start = (c == 3);
      end
      #1 exp_v = exp_q.pop_front(); total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rst_mid c%0d: got %h want %h", c, obs, exp_v); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    clear_flags();
    test_reset();
    test_tick();
    test_move_priority();
    test_score();
    test_game_over();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
